// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO family.
package fifo_pkg;

    // Index width of the storage array; pointers carry one extra wrap bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents never reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = 5
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with selectable registered/FWFT read, fill count, thresholds,
// sticky overflow/underflow, synchronous flush and write-through when full.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    wr_i,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    rd_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    valid_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic [addr_w(DEPTH):0]  count_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int AW = addr_w(DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_C  = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    logic [AW:0]       wr_ptr_reg;
    logic [AW:0]       rd_ptr_reg;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              rd_acc;
    logic              wr_acc;
    logic              overflow_reg;
    logic              underflow_reg;
    logic [DATA_W-1:0] mem_rdata;

    // Modular difference of the wrap-bit pointers gives occupancy directly.
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    assign rd_acc = rd_i & ~empty;
    assign wr_acc = wr_i & (~full | rd_acc);

    assign count_o        = count;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count >= AFULL_C);
    assign almost_empty_o = (count <= AEMPTY_C);
    assign overflow_o     = overflow_reg;
    assign underflow_o    = underflow_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (wr_i & ~wr_acc) begin
                overflow_reg <= 1'b1;
            end
            if (rd_i & empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // When full, waddr equals raddr; the async read still returns the old head this cycle.
    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i (clk_i),
        .we    (wr_acc & ~clr_i),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (data_i),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (clr_i) begin
                    valid_reg <= 1'b0;
                end else if (rd_acc) begin
                    data_reg  <= mem_rdata;
                    valid_reg <= 1'b1;
                end else begin
                    valid_reg <= 1'b0;
                end
            end

            assign data_o  = data_reg;
            assign valid_o = valid_reg;
        end else begin : g_fwft
            assign data_o  = mem_rdata;
            assign valid_o = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a registered-read instance driven against a queue model
// and scoreboard, plus a first-word-fall-through instance.
`timescale 1ns/1ps
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instance
    logic       clr0 = 1'b0, wr0 = 1'b0, rd0 = 1'b0;
    logic [7:0] din0 = '0, data0;
    logic       valid0, full0, empty0, afull0, aempty0, ov0, un0;
    logic [5:0] count0;

    // First-word-fall-through instance
    logic       clr1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
    logic [7:0] din1 = '0, data1;
    logic       valid1, full1, empty1, afull1, aempty1, ov1, un1;
    logic [5:0] count1;

    param_fifo #(.DATA_W(8), .DEPTH(32), .FWFT(0), .AFULL_TH(28), .AEMPTY_TH(4)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr0), .wr_i(wr0), .data_i(din0), .rd_i(rd0),
        .data_o(data0), .valid_o(valid0), .full_o(full0), .empty_o(empty0),
        .almost_full_o(afull0), .almost_empty_o(aempty0), .count_o(count0),
        .overflow_o(ov0), .underflow_o(un0)
    );

    param_fifo #(.DATA_W(8), .DEPTH(32), .FWFT(1), .AFULL_TH(28), .AEMPTY_TH(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr1), .wr_i(wr1), .data_i(din1), .rd_i(rd1),
        .data_o(data1), .valid_o(valid1), .full_o(full1), .empty_o(empty1),
        .almost_full_o(afull1), .almost_empty_o(aempty1), .count_o(count1),
        .overflow_o(ov1), .underflow_o(un1)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mq[$];     // model FIFO contents
    logic [7:0] sb_q[$];   // words expected on data0 when valid0 is high
    logic       m_ov = 1'b0;
    logic       m_un = 1'b0;

    // Scoreboard monitor: every valid0 word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && valid0) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got valid data %h, required no valid word", data0);
            end else begin
                logic [7:0] exp_w;
                exp_w = sb_q.pop_front();
                if (data0 !== exp_w) begin
                    n_err++;
                    $display("FAIL sb_data: got %h, required %h", data0, exp_w);
                end
            end
        end
    end

    // Drive one cycle on dut0 and advance the model; returns 1 ns after the edge.
    task automatic drive0(input logic wr, input logic rd, input logic clr, input logic [7:0] d);
        bit e, f, ra, wa;
        wr0 = wr; rd0 = rd; clr0 = clr; din0 = d;
        if (clr) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            e  = (mq.size() == 0);
            f  = (mq.size() == 32);
            ra = rd && !e;
            wa = wr && (!f || ra);
            if (rd && e) m_un = 1'b1;
            if (wr && !wa) m_ov = 1'b1;
            if (ra) sb_q.push_back(mq.pop_front());
            if (wa) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
        $display("txn dut0 wr=%0b rd=%0b clr=%0b d=%h -> count=%0d valid=%0b data=%h",
                 wr, rd, clr, d, count0, valid0, data0);
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (count0 !== 6'd0 || count1 !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d/%0d, required 0/0", count0, count1); end
        n_cmp++; if (empty0 !== 1'b1 || empty1 !== 1'b1 || aempty0 !== 1'b1 || aempty1 !== 1'b1) begin n_err++; $display("FAIL reset_empty: got e=%b%b ae=%b%b, required all 1", empty0, empty1, aempty0, aempty1); end
        n_cmp++; if (full0 !== 1'b0 || full1 !== 1'b0 || afull0 !== 1'b0 || afull1 !== 1'b0) begin n_err++; $display("FAIL reset_full: got f=%b%b af=%b%b, required all 0", full0, full1, afull0, afull1); end
        n_cmp++; if (valid0 !== 1'b0 || valid1 !== 1'b0 || data0 !== 8'h00) begin n_err++; $display("FAIL reset_out: got v=%b%b d=%h, required 0 0 00", valid0, valid1, data0); end
        n_cmp++; if (ov0 !== 1'b0 || un0 !== 1'b0 || ov1 !== 1'b0 || un1 !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got %b%b%b%b, required 0000", ov0, un0, ov1, un1); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 32; i++) begin
            drive0(1'b1, 1'b0, 1'b0, 8'(i));
            n_cmp++; if (count0 !== 6'(i + 1)) begin n_err++; $display("FAIL fill_count: got %0d, required %0d", count0, i + 1); end
            n_cmp++; if (afull0 !== (i + 1 >= 28) || aempty0 !== (i + 1 <= 4)) begin n_err++; $display("FAIL fill_thresh: got af=%b ae=%b at count %0d", afull0, aempty0, i + 1); end
            n_cmp++; if (full0 !== (i == 31)) begin n_err++; $display("FAIL fill_full: got %b at count %0d", full0, i + 1); end
        end
        drive0(1'b1, 1'b0, 1'b0, 8'hEE);
        n_cmp++; if (ov0 !== 1'b1 || count0 !== 6'd32) begin n_err++; $display("FAIL overflow: got ov=%b count=%0d, required 1 32", ov0, count0); end
        n_cmp++; if (un0 !== 1'b0) begin n_err++; $display("FAIL overflow_un: got un=%b, required 0", un0); end
    endtask

    task automatic test_read;
        for (int i = 0; i < 32; i++) begin
            drive0(1'b0, 1'b1, 1'b0, 8'h00);
            n_cmp++; if (valid0 !== 1'b1 || data0 !== 8'(i)) begin n_err++; $display("FAIL read_word: got v=%b d=%h, required 1 %h", valid0, data0, 8'(i)); end
        end
        n_cmp++; if (empty0 !== 1'b1 || count0 !== 6'd0) begin n_err++; $display("FAIL read_empty: got e=%b count=%0d, required 1 0", empty0, count0); end
        drive0(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++; if (valid0 !== 1'b0 || data0 !== 8'h1F) begin n_err++; $display("FAIL read_pulse: got v=%b d=%h, required 0 1f", valid0, data0); end
    endtask

    task automatic test_write_through;
        drive0(1'b0, 1'b0, 1'b1, 8'h00);
        n_cmp++; if (ov0 !== 1'b0 || count0 !== 6'd0) begin n_err++; $display("FAIL wt_clr: got ov=%b count=%0d, required 0 0", ov0, count0); end
        for (int i = 0; i < 32; i++) drive0(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        drive0(1'b1, 1'b1, 1'b0, 8'hAA);
        n_cmp++; if (count0 !== 6'd32 || full0 !== 1'b1 || ov0 !== 1'b0) begin n_err++; $display("FAIL wt_count: got count=%0d f=%b ov=%b, required 32 1 0", count0, full0, ov0); end
        n_cmp++; if (data0 !== 8'h40 || valid0 !== 1'b1) begin n_err++; $display("FAIL wt_head: got v=%b d=%h, required 1 40", valid0, data0); end
        for (int i = 1; i <= 32; i++) begin
            logic [7:0] exp_w;
            exp_w = (i == 32) ? 8'hAA : 8'(8'h40 + i);
            drive0(1'b0, 1'b1, 1'b0, 8'h00);
            n_cmp++; if (data0 !== exp_w) begin n_err++; $display("FAIL wt_order: got %h, required %h (read %0d)", data0, exp_w, i); end
        end
        n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL wt_empty: got %b, required 1", empty0); end
    endtask

    task automatic test_underflow_clr;
        drive0(1'b1, 1'b1, 1'b0, 8'h33);
        n_cmp++; if (un0 !== 1'b1 || count0 !== 6'd1 || valid0 !== 1'b0) begin n_err++; $display("FAIL underflow: got un=%b count=%0d v=%b, required 1 1 0", un0, count0, valid0); end
        drive0(1'b1, 1'b0, 1'b0, 8'h34);
        n_cmp++; if (count0 !== 6'd2) begin n_err++; $display("FAIL underflow_fill: got %0d, required 2", count0); end
        drive0(1'b1, 1'b1, 1'b1, 8'h35);
        n_cmp++; if (count0 !== 6'd0 || un0 !== 1'b0 || ov0 !== 1'b0 || empty0 !== 1'b1 || valid0 !== 1'b0) begin n_err++; $display("FAIL clr: got count=%0d un=%b ov=%b e=%b v=%b, required 0 0 0 1 0", count0, un0, ov0, empty0, valid0); end
    endtask

    task automatic test_fwft;
        wr1 = 1'b1; din1 = 8'h5A;
        #1;
        n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL fwft_pre: got v=%b, required 0", valid1); end
        @(posedge clk); #1;
        wr1 = 1'b0;
        $display("txn dut1 wr d=5a -> count=%0d valid=%0b data=%h", count1, valid1, data1);
        n_cmp++; if (valid1 !== 1'b1 || data1 !== 8'h5A || count1 !== 6'd1) begin n_err++; $display("FAIL fwft_show: got v=%b d=%h count=%0d, required 1 5a 1", valid1, data1, count1); end
        rd1 = 1'b1;
        @(posedge clk); #1;
        rd1 = 1'b0;
        $display("txn dut1 rd -> count=%0d valid=%0b", count1, valid1);
        n_cmp++; if (empty1 !== 1'b1 || valid1 !== 1'b0) begin n_err++; $display("FAIL fwft_pop: got e=%b v=%b, required 1 0", empty1, valid1); end
        for (int i = 0; i < 3; i++) begin
            wr1 = 1'b1; din1 = 8'(8'hC0 + i);
            @(posedge clk); #1;
        end
        wr1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (valid1 !== 1'b1 || data1 !== 8'(8'hC0 + i)) begin n_err++; $display("FAIL fwft_head: got v=%b d=%h, required 1 %h", valid1, data1, 8'(8'hC0 + i)); end
            rd1 = 1'b1;
            @(posedge clk); #1;
            rd1 = 1'b0;
            $display("txn dut1 rd -> count=%0d valid=%0b data=%h", count1, valid1, data1);
        end
        n_cmp++; if (empty1 !== 1'b1 || un1 !== 1'b0 || ov1 !== 1'b0) begin n_err++; $display("FAIL fwft_end: got e=%b un=%b ov=%b, required 1 0 0", empty1, un1, ov1); end
    endtask

    task automatic test_random_reset;
        for (int i = 0; i < 140; i++) begin
            drive0($urandom_range(0, 3) != 0, $urandom_range(0, 7) < 5, 1'b0, 8'($urandom));
            n_cmp++; if (count0 !== 6'(mq.size()) || full0 !== (mq.size() == 32) || empty0 !== (mq.size() == 0)) begin n_err++; $display("FAIL rand_count: got count=%0d f=%b e=%b, required %0d", count0, full0, empty0, mq.size()); end
            n_cmp++; if (ov0 !== m_ov || un0 !== m_un) begin n_err++; $display("FAIL rand_sticky: got ov=%b un=%b, required %b %b", ov0, un0, m_ov, m_un); end
        end
        // Asynchronous reset in the middle of an active cycle
        wr0 = 1'b1; rd0 = 1'b1; din0 = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        $display("txn async reset -> count=%0d valid=%0b data=%h", count0, valid0, data0);
        n_cmp++; if (count0 !== 6'd0 || empty0 !== 1'b1 || full0 !== 1'b0) begin n_err++; $display("FAIL areset_ptr: got count=%0d e=%b f=%b, required 0 1 0", count0, empty0, full0); end
        n_cmp++; if (valid0 !== 1'b0 || data0 !== 8'h00 || ov0 !== 1'b0 || un0 !== 1'b0) begin n_err++; $display("FAIL areset_out: got v=%b d=%h ov=%b un=%b, required 0 00 0 0", valid0, data0, ov0, un0); end
        wr0 = 1'b0; rd0 = 1'b0;
        mq.delete(); sb_q.delete(); m_ov = 1'b0; m_un = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive0(1'b1, 1'b0, 1'b0, 8'h11);
        drive0(1'b1, 1'b0, 1'b0, 8'h22);
        drive0(1'b0, 1'b1, 1'b0, 8'h00);
        drive0(1'b0, 1'b1, 1'b0, 8'h00);
        drive0(1'b0, 1'b0, 1'b0, 8'h00);
        n_cmp++; if (count0 !== 6'd0 || sb_q.size() != 0) begin n_err++; $display("FAIL post_reset: got count=%0d pending=%0d, required 0 0", count0, sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read();
        test_write_through();
        test_underflow_clr();
        test_fwft();
        test_random_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
